cpu_mem_req_arbiter: RTL and testbench
======================================

// Module: cpu_mem_req_arbiter
// PURPOSE
//   Multi-channel memory bus request arbiter and queue between the cache controllers (I$, D$, ...)
//   and main memory. Each channel presents a line-granular read/write request. A round-robin arbiter
//   accepts one request per cycle into a QUEUE_DEPTH FIFO. The FIFO head drives a single memory
//   request port with a ready handshake and a channel-ID tag for routing responses.
// PARAMETERS
//   NUM_CH       4                                                            requesting channels (>=2)
//   LINE_WIDTH   `LINE_WIDTH                                                  data bits per request (one cache line)
//   ADDR_WIDTH   `PHYSICAL_ADDR_WIDTH-$clog2(`LINE_WIDTH/`BYTE_WIDTH)          line address bits
//   QUEUE_DEPTH  4                                                            FIFO entries (power of 2, >=2)
//   ID_WIDTH     $clog2(NUM_CH)  (localparam)                                 channel tag bits
// PORTS
//   clk          in   1                        clock, all state on rising edge
//   rst_n        in   1                        asynchronous active-low reset
//   ch_read      in   NUM_CH                   per-channel read request
//   ch_write     in   NUM_CH                   per-channel write request
//   ch_data      in   NUM_CH*LINE_WIDTH        write data, channel i at [i*LINE_WIDTH +: LINE_WIDTH]
//   ch_addr      in   NUM_CH*ADDR_WIDTH        line address, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   ch_ready     out  NUM_CH                   one-hot grant: channel's request accepted this cycle
//   mem_read     out  1                        head entry is a read
//   mem_write    out  1                        head entry is a write
//   mem_data     out  LINE_WIDTH               head write data
//   mem_addr     out  ADDR_WIDTH               head line address
//   mem_id       out  ID_WIDTH                 originating channel of head entry
//   mem_ready    in   1                        memory consumes head when (mem_read|mem_write)&mem_ready
//   occupancy    out  $clog2(QUEUE_DEPTH)+1    FIFO entries in use
//   illegal      out  1                        one-cycle pulse: accepted request had read&write both set
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFO empty, rd/wr pointers 0, rr pointer = NUM_CH-1,
//     mem_read/mem_write/mem_data/mem_addr/mem_id=0, occupancy=0, illegal=0, ch_ready=0.
//   - Channel i requests when ch_read[i]|ch_write[i]; request must be held until ch_ready[i].
//   - Arbitration (combinational): grant the first requesting channel after rr pointer, wrapping
//     NUM_CH-1 -> 0. Grant only if FIFO not full, or full and head pops this cycle (pop frees slot).
//   - ch_ready is the grant, one-hot or zero, same cycle as the request. On grant: push entry, rr
//     pointer <= granted index. No grant -> rr pointer unchanged.
//   - read&write both set: entry stored as write (mem_read=0); illegal pulses the following cycle.
//   - FIFO: registered storage, head outputs driven from FIFO registers. mem_read/mem_write are 0
//     when empty; mem_data/addr/id hold last value (don't-care).
//   - Latency: request accepted in cycle N into empty FIFO -> visible on mem_* in cycle N+1.
//     No same-cycle bypass.
//   - Pop when head valid & mem_ready; pointers wrap modulo QUEUE_DEPTH.
//   - Simultaneous push and pop: occupancy unchanged, both permitted even when full.
//   - mem_ready while empty: ignored, occupancy stays 0.
//   - Head fields stable while valid and mem_ready=0.
//   - Reset mid-operation: queued requests discarded, no partial output.
//   - occupancy never exceeds QUEUE_DEPTH; full = (occupancy==QUEUE_DEPTH).
// TESTING
//   1. ch0 read addr 0x12, mem_ready=1 -> ch_ready=4'b0001 cycle N; N+1: mem_read=1, mem_addr=0x12,
//      mem_id=0; N+2 occupancy=0.
//   2. All 4 channels read continuously, mem_ready=1 -> grant order 0,1,2,3,0,1; mem_id follows one
//      cycle later; occupancy stays 1.
//   3. mem_ready=0, 5 requests on ch1 -> 4 accepted, occupancy=4, ch_ready=0 on 5th; then mem_ready=1
//      for one cycle -> 5th accepted same cycle, occupancy stays 4.
//   4. ch2 read=1 write=1 data=0xA5.., addr 0x3 -> mem_write=1, mem_read=0, mem_id=2; illegal=1 for
//      exactly one cycle.
//   5. occupancy=3 then rst_n low mid-cycle -> mem_read=mem_write=0, occupancy=0 immediately; after
//      release with all channels requesting, first grant is ch0.
//   6. Random multi-channel traffic + random mem_ready, 10k cycles -> every request issued exactly
//      once, per-channel order preserved, no channel starved > NUM_CH grants.

Source files
------------

// File: rtl/cpu_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_req_arbiter
// Description : Round-robin arbiter that collects line-granular read/write
//               requests from NUM_CH cache-controller channels into a
//               QUEUE_DEPTH-entry FIFO. The FIFO head drives a single memory
//               request port with a ready handshake and a channel-ID tag.
// Ports       : clk, rst_n                   clock / async active-low reset
//               ch_read, ch_write            per-channel request strobes
//               ch_data, ch_addr             per-channel packed payloads
//               ch_ready                     one-hot grant (same cycle)
//               mem_read, mem_write          head entry valid + type
//               mem_data, mem_addr, mem_id   head entry payload and tag
//               mem_ready                    memory consumes the head
//               occupancy                    FIFO entries in use
//               illegal                      pulse: accepted read&write request
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef LINE_WIDTH
  `define LINE_WIDTH 64
`endif
`ifndef BYTE_WIDTH
  `define BYTE_WIDTH 8
`endif
`ifndef PHYSICAL_ADDR_WIDTH
  `define PHYSICAL_ADDR_WIDTH 32
`endif

module cpu_mem_req_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int LINE_WIDTH  = `LINE_WIDTH,
  parameter int ADDR_WIDTH  = `PHYSICAL_ADDR_WIDTH - $clog2(`LINE_WIDTH / `BYTE_WIDTH),
  parameter int QUEUE_DEPTH = 4,
  localparam int ID_WIDTH   = $clog2(NUM_CH),
  localparam int CNT_WIDTH  = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_read,
  input  logic [NUM_CH-1:0]            ch_write,
  input  logic [NUM_CH*LINE_WIDTH-1:0] ch_data,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [LINE_WIDTH-1:0]        mem_data,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [ID_WIDTH-1:0]          mem_id,
  input  logic                         mem_ready,
  output logic [CNT_WIDTH-1:0]         occupancy,
  output logic                         illegal
);

  localparam int c_PTR_WIDTH = $clog2(QUEUE_DEPTH);

  // FIFO storage
  logic [LINE_WIDTH-1:0]  r_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  r_addr [QUEUE_DEPTH];
  logic [ID_WIDTH-1:0]    r_id   [QUEUE_DEPTH];
  logic                   r_wr   [QUEUE_DEPTH];

  logic [c_PTR_WIDTH-1:0] r_wr_ptr;
  logic [c_PTR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [ID_WIDTH-1:0]    r_rr_ptr;
  logic                   r_illegal;

  logic [NUM_CH-1:0]      w_req;
  logic                   w_found;
  logic [ID_WIDTH-1:0]    w_grant_idx;
  logic [ID_WIDTH-1:0]    w_scan_idx;
  logic                   w_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_can_push;
  logic                   w_push;
  logic                   w_push_wr;
  logic                   w_push_rw;
  logic [LINE_WIDTH-1:0]  w_push_data;
  logic [ADDR_WIDTH-1:0]  w_push_addr;

  assign w_req      = ch_read | ch_write;
  assign w_valid    = (r_count != '0);
  assign w_full     = (r_count == CNT_WIDTH'(QUEUE_DEPTH));
  assign w_pop      = w_valid & mem_ready;
  // A pop in the same cycle frees the slot the push is about to take.
  assign w_can_push = ~w_full | w_pop;

  // Scan channels starting just after the last winner and wrapping, so the
  // most recently served channel has lowest priority.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_scan_idx = ID_WIDTH'((int'(r_rr_ptr) + k) % NUM_CH);
      if (!w_found && w_req[w_scan_idx]) begin
        w_found     = 1'b1;
        w_grant_idx = w_scan_idx;
      end
    end
  end

  // rst_n gates the grant so no channel sees ch_ready while the queue is held
  // in reset.
  assign w_push      = w_found & w_can_push & rst_n;
  assign w_push_wr   = ch_write[w_grant_idx];
  assign w_push_rw   = ch_read[w_grant_idx] & ch_write[w_grant_idx];
  assign w_push_data = ch_data[int'(w_grant_idx)*LINE_WIDTH +: LINE_WIDTH];
  assign w_push_addr = ch_addr[int'(w_grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    ch_ready = '0;
    if (w_push) begin
      ch_ready[w_grant_idx] = 1'b1;
    end
  end

  // Storage is reset as well so the head fields read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_data[i] <= '0;
        r_addr[i] <= '0;
        r_id[i]   <= '0;
        r_wr[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_data[r_wr_ptr] <= w_push_data;
      r_addr[r_wr_ptr] <= w_push_addr;
      r_id[r_wr_ptr]   <= w_grant_idx;
      // read&write together is stored as a write
      r_wr[r_wr_ptr]   <= w_push_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rr_ptr  <= ID_WIDTH'(NUM_CH - 1);
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= w_push & w_push_rw;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_WIDTH'(1);
        r_rr_ptr <= w_grant_idx;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_WIDTH'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_WIDTH'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_WIDTH'(1);
      end
    end
  end

  assign mem_read  = w_valid & ~r_wr[r_rd_ptr];
  assign mem_write = w_valid &  r_wr[r_rd_ptr];
  assign mem_data  = r_data[r_rd_ptr];
  assign mem_addr  = r_addr[r_rd_ptr];
  assign mem_id    = r_id[r_rd_ptr];
  assign occupancy = r_count;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_mem_req_arbiter
// Description : Scoreboard bench for cpu_mem_req_arbiter. Stimulus predicts
//               grants from the round-robin rule and pushes accepted requests
//               into an expected queue; a monitor compares the memory port
//               against the queue head every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_mem_req_arbiter;

  localparam int NUM_CH = 4;
  localparam int LW     = 64;
  localparam int AW     = 29;
  localparam int QD     = 4;
  localparam int IDW    = 2;
  localparam int CW     = 3;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NUM_CH-1:0]      ch_read;
  logic [NUM_CH-1:0]      ch_write;
  logic [NUM_CH*LW-1:0]   ch_data;
  logic [NUM_CH*AW-1:0]   ch_addr;
  logic [NUM_CH-1:0]      ch_ready;
  logic                   mem_read;
  logic                   mem_write;
  logic [LW-1:0]          mem_data;
  logic [AW-1:0]          mem_addr;
  logic [IDW-1:0]         mem_id;
  logic                   mem_ready;
  logic [CW-1:0]          occupancy;
  logic                   illegal;

  always #5 clk = ~clk;

  cpu_mem_req_arbiter #(
    .NUM_CH      (NUM_CH),
    .LINE_WIDTH  (LW),
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_read   (ch_read),
    .ch_write  (ch_write),
    .ch_data   (ch_data),
    .ch_addr   (ch_addr),
    .ch_ready  (ch_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .mem_id    (mem_id),
    .mem_ready (mem_ready),
    .occupancy (occupancy),
    .illegal   (illegal)
  );

  typedef struct {
    logic          wr;
    logic [LW-1:0] data;
    logic [AW-1:0] addr;
    int            id;
  } ent_t;

  // Expected memory-side order of accepted requests.
  ent_t q[$];

  int              checks = 0;
  int              errors = 0;
  int              rr;
  logic            exp_ill;
  int              wait_cnt [NUM_CH];
  logic [NUM_CH-1:0] last_grant;
  int              addr_ctr = 16'h100;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr,
                         input logic [LW-1:0] d, input logic [AW-1:0] a);
    ch_read[c]          = rd;
    ch_write[c]         = wr;
    ch_data[c*LW +: LW] = d;
    ch_addr[c*AW +: AW] = a;
  endtask

  task automatic clr_req(input int c);
    ch_read[c]  = 1'b0;
    ch_write[c] = 1'b0;
  endtask

  function automatic logic [AW-1:0] next_addr();
    addr_ctr++;
    return AW'(addr_ctr);
  endfunction

  // One clock cycle: predict and check the grant at the falling edge, commit
  // the accepted request to the expected queue at the rising edge.
  task automatic step();
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] expv;
    int                g;
    bit                can;
    ent_t              e;
    @(negedge clk);
    req  = ch_read | ch_write;
    can  = (q.size() < QD) || (q.size() > 0 && mem_ready);
    g    = -1;
    if (can) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int c;
        c = (rr + k) % NUM_CH;
        if (g < 0 && req[c]) g = c;
      end
    end
    expv = '0;
    if (g >= 0) expv[g] = 1'b1;
    chk("ch_ready", 64'(ch_ready), 64'(expv));
    chk("illegal", 64'(illegal), 64'(exp_ill));
    last_grant = ch_ready;
    if (ch_ready != '0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_ready[i]) begin
          chk("starvation", 64'(wait_cnt[i] <= NUM_CH), 64'd1);
          wait_cnt[i] = 0;
        end else if (req[i]) begin
          wait_cnt[i]++;
        end
      end
    end
    exp_ill = (g >= 0) && ch_read[g] && ch_write[g];
    if (g >= 0) begin
      e.wr   = ch_write[g];
      e.data = ch_data[g*LW +: LW];
      e.addr = ch_addr[g*AW +: AW];
      e.id   = g;
    end
    @(posedge clk);
    if (g >= 0) begin
      q.push_back(e);
      rr = g;
    end
    #1;
  endtask

  // Asserts reset partway into the cycle, checks the outputs clear at once,
  // then releases just after a rising edge.
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    q.delete();
    rr      = NUM_CH - 1;
    exp_ill = 1'b0;
    for (int i = 0; i < NUM_CH; i++) wait_cnt[i] = 0;
    last_grant = '0;
    #1;
    chk("rst_mem_read",  64'(mem_read),  64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    chk("rst_ch_ready",  64'(ch_ready),  64'd0);
    chk("rst_mem_addr",  64'(mem_addr),  64'd0);
    chk("rst_mem_id",    64'(mem_id),    64'd0);
    chk("rst_mem_data",  64'(mem_data),  64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compare the memory port with the expected head each cycle.
  initial begin : monitor
    bit pop;
    ent_t e;
    forever begin
      @(negedge clk);
      pop = 1'b0;
      if (!rst_n) begin
        chk("mon_rst_valid", 64'(mem_read | mem_write), 64'd0);
        chk("mon_rst_occ",   64'(occupancy),           64'd0);
        chk("mon_rst_ready", 64'(ch_ready),            64'd0);
      end else begin
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        if (q.size() == 0) begin
          chk("idle_valid", 64'(mem_read | mem_write), 64'd0);
        end else begin
          e = q[0];
          chk("mem_write", 64'(mem_write), 64'(e.wr));
          chk("mem_read",  64'(mem_read),  64'(!e.wr));
          chk("mem_id",    64'(mem_id),    64'(e.id));
          chk("mem_addr",  64'(mem_addr),  64'(e.addr));
          if (e.wr) chk("mem_data", 64'(mem_data), 64'(e.data));
          pop = mem_ready;
        end
      end
      @(posedge clk);
      if (pop) void'(q.pop_front());
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    rst_n     = 1'b0;
    ch_read   = '0;
    ch_write  = '0;
    ch_data   = '0;
    ch_addr   = '0;
    mem_ready = 1'b0;
    rr        = NUM_CH - 1;
    exp_ill   = 1'b0;
    last_grant = '0;
    for (int i = 0; i < NUM_CH; i++) wait_cnt[i] = 0;
    @(posedge clk);
    #1;
    do_reset();

    // single read on ch0, lands on memory port next cycle
    mem_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, '0, AW'('h12));
    step();
    chk("t1_grant", 64'(last_grant), 64'h1);
    clr_req(0);
    chk("t1_mem_read", 64'(mem_read), 64'd1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h12);
    chk("t1_mem_id",   64'(mem_id),   64'd0);
    step();
    chk("t1_occ", 64'(occupancy), 64'd0);
    step();

    // all channels reading continuously: rotation 0,1,2,3,0,1
    do_reset();
    mem_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b1, 1'b0, '0, next_addr());
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t2_order", 64'(last_grant), 64'(1 << (k % NUM_CH)));
      chk("t2_occ",   64'(occupancy),  64'd1);
      for (int c = 0; c < NUM_CH; c++)
        if (last_grant[c]) set_req(c, 1'b1, 1'b0, '0, next_addr());
    end
    for (int c = 0; c < NUM_CH; c++) clr_req(c);
    repeat (3) step();

    // fill to full with memory stalled, then pop and push together
    do_reset();
    mem_ready = 1'b0;
    set_req(1, 1'b1, 1'b0, '0, next_addr());
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_grant", 64'(last_grant), (k < QD) ? 64'h2 : 64'h0);
      if (last_grant[1]) set_req(1, 1'b1, 1'b0, '0, next_addr());
    end
    chk("t3_full", 64'(occupancy), 64'd4);
    mem_ready = 1'b1;
    step();
    chk("t3_pushpop_grant", 64'(last_grant), 64'h2);
    chk("t3_pushpop_occ",   64'(occupancy),  64'd4);
    clr_req(1);
    repeat (6) step();

    // read&write together: stored as write, illegal pulses once
    do_reset();
    mem_ready = 1'b0;
    set_req(2, 1'b1, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, AW'('h3));
    step();
    clr_req(2);
    chk("t4_illegal_hi", 64'(illegal),   64'd1);
    chk("t4_mem_write",  64'(mem_write), 64'd1);
    chk("t4_mem_read",   64'(mem_read),  64'd0);
    chk("t4_mem_id",     64'(mem_id),    64'd2);
    chk("t4_mem_data",   64'(mem_data),  64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk("t4_illegal_lo", 64'(illegal), 64'd0);
    mem_ready = 1'b1;
    repeat (2) step();

    // reset with three entries queued
    do_reset();
    mem_ready = 1'b0;
    set_req(3, 1'b1, 1'b0, '0, next_addr());
    for (int k = 0; k < 3; k++) begin
      step();
      if (last_grant[3]) set_req(3, 1'b1, 1'b0, '0, next_addr());
    end
    chk("t5_occ3", 64'(occupancy), 64'd3);
    for (int c = 0; c < NUM_CH; c++) set_req(c, 1'b1, 1'b0, '0, next_addr());
    do_reset();
    step();
    chk("t5_first_grant", 64'(last_grant), 64'h1);
    for (int c = 0; c < NUM_CH; c++) clr_req(c);
    mem_ready = 1'b1;
    repeat (3) step();

    // random traffic
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (last_grant[c]) clr_req(c);
        if (!(ch_read[c] | ch_write[c]) && $urandom_range(0, 99) < 40) begin
          t = $urandom_range(0, 9);
          if (t == 0)      set_req(c, 1'b1, 1'b1, {$urandom, $urandom}, next_addr());
          else if (t < 5)  set_req(c, 1'b1, 1'b0, {$urandom, $urandom}, next_addr());
          else             set_req(c, 1'b0, 1'b1, {$urandom, $urandom}, next_addr());
        end
      end
      mem_ready = ($urandom_range(0, 99) < 60);
      step();
    end
    for (int c = 0; c < NUM_CH; c++)
      if (last_grant[c]) clr_req(c);
    // let still-pending requests get in, then drain
    mem_ready = 1'b1;
    for (int n = 0; n < 40 && ((ch_read | ch_write) != '0 || q.size() > 0); n++) begin
      step();
      for (int c = 0; c < NUM_CH; c++)
        if (last_grant[c]) clr_req(c);
    end
    chk("drain_pending", 64'(ch_read | ch_write), 64'd0);
    chk("drain_occ",     64'(occupancy),          64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
